fas_stream_checker: RTL

//  Synthesizable, parametrised result checker for FAS output streams (FIR: 1 lane real; FFT: 16 lanes complex).

---
 rtl/fas_chk_pkg.sv | 18 +
 rtl/fas_stream_checker_if.sv | 35 +++
 rtl/fas_tol_cmp.sv | 17 +
 rtl/fas_stream_checker.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fas_chk_pkg.sv
// Shared types and width helpers for the FAS stream checker.
package fas_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RUN, ST_DRAIN, ST_PASS, ST_FAIL, ST_TIMEOUT
    } state_e;

    // Word width: complex words carry {re, im}.
    function automatic int cw_f(input int dw, input int cplx);
        return (cplx != 0) ? 2 * dw : dw;
    endfunction

    // Index width for a range of n values, never zero.
    function automatic int aw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fas_stream_checker_if.sv
// Golden-load, DUT-beat and status signals of the FAS stream checker.
interface fas_stream_checker_if #(
    parameter int DW        = 16,
    parameter int LANES     = 1,
    parameter int COMPLEX   = 0,
    parameter int NUM_BEATS = 1024
);
    localparam int CW = fas_chk_pkg::cw_f(DW, COMPLEX);
    localparam int AW = fas_chk_pkg::aw_f(NUM_BEATS);

    logic                       gold_we;
    logic [AW-1:0]              gold_addr;
    logic [LANES-1:0][CW-1:0]   gold_wdata;
    logic                       start;
    logic                       dut_valid;
    logic [LANES-1:0][CW-1:0]   dut_data;
    logic                       busy;
    logic                       pass;
    logic                       fail;
    logic                       timeout;
    logic                       err_pulse;
    logic [15:0]                err_count;
    logic [AW-1:0]              first_err;

    modport master (
        output gold_we, gold_addr, gold_wdata, start, dut_valid, dut_data,
        input  busy, pass, fail, timeout, err_pulse, err_count, first_err
    );

    modport slave (
        input  gold_we, gold_addr, gold_wdata, start, dut_valid, dut_data,
        output busy, pass, fail, timeout, err_pulse, err_count, first_err
    );

endinterface

// File: rtl/fas_tol_cmp.sv
// One-component tolerance compare: (dut - gold) mod 2^DW read as signed, OK iff within +/-TOL.
module fas_tol_cmp #(
    parameter int DW  = 16,
    parameter int TOL = 1
) (
    input  logic [DW-1:0] dut_i,
    input  logic [DW-1:0] gold_i,
    output logic          ok_o
);
    logic [DW-1:0] diff;
    int            d;

    assign diff = dut_i - gold_i;
    assign d    = int'($signed(diff));
    assign ok_o = (d >= -TOL) && (d <= TOL);

endmodule

// File: rtl/fas_stream_checker.sv
// FAS output stream checker: golden-table compare within +/-TOL per component,
// failing-lane counting, fail-limit abort and idle timeout.
module fas_stream_checker
    import fas_chk_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LANES      = 1,
    parameter int COMPLEX    = 0,
    parameter int TOL        = 1,
    parameter int NUM_BEATS  = 1024,
    parameter int FAIL_LIMIT = 48,
    parameter int TIMEOUT    = 4096
) (
    input logic                 clk,
    input logic                 rst,
    fas_stream_checker_if.slave bus
);
    localparam int CW = cw_f(DW, COMPLEX);
    localparam int NH = (COMPLEX != 0) ? 2 : 1;
    localparam int AW = aw_f(NUM_BEATS);
    localparam int TW = aw_f(TIMEOUT + 1);
    localparam int NW = aw_f(LANES + 1);

    state_e                   state_q, state_d;
    logic [AW-1:0]            beat_q, beat_d, idx_q, idx_d, ferr_q, ferr_d;
    logic [TW-1:0]            idle_q, idle_d;
    logic [15:0]              cnt_q, cnt_d;
    logic                     vld_q, vld_d, epulse_q, epulse_d;
    logic [LANES-1:0][CW-1:0] mem [NUM_BEATS];
    logic [LANES-1:0][CW-1:0] gold_q, dut_q;
    logic [LANES-1:0][NH-1:0] ok;
    logic [LANES-1:0]         lane_bad;
    logic [NW-1:0]            nbad;
    logic [16:0]              cnt_sum;
    logic                     cmp_en, accept, busy;

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Golden RAM is frozen while a run is in flight, so reads never race writes.
    always_ff @(posedge clk) begin
        if (bus.gold_we && !busy) mem[bus.gold_addr] <= bus.gold_wdata;
        if (accept) begin
            gold_q <= mem[beat_q];
            dut_q  <= bus.dut_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar h = 0; h < NH; h++) begin : g_half
            fas_tol_cmp #(.DW(DW), .TOL(TOL)) u_cmp (
                .dut_i (dut_q[l][h*DW +: DW]),
                .gold_i(gold_q[l][h*DW +: DW]),
                .ok_o  (ok[l][h])
            );
        end
        assign lane_bad[l] = ~&ok[l];
    end

    always_comb begin
        nbad = '0;
        for (int l = 0; l < LANES; l++) nbad = nbad + NW'(lane_bad[l]);
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        idx_d    = idx_q;
        idle_d   = idle_q;
        cnt_d    = cnt_q;
        ferr_d   = ferr_q;
        vld_d    = 1'b0;
        epulse_d = 1'b0;
        accept   = 1'b0;
        cnt_sum  = {1'b0, cnt_q} + 17'(nbad);
        // A beat still in flight when the run has ended is dropped.
        cmp_en   = vld_q && busy;

        if (cmp_en) begin
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (nbad != '0) begin
                epulse_d = 1'b1;
                if (cnt_q == '0) ferr_d = idx_q;
            end
        end

        unique case (state_q)
            ST_RUN: begin
                accept = bus.dut_valid;
                if (accept) begin
                    vld_d  = 1'b1;
                    idx_d  = beat_q;
                    beat_d = beat_q + 1'b1;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                if (cmp_en && 32'(cnt_d) >= FAIL_LIMIT)         state_d = ST_FAIL;
                else if (accept && beat_q == AW'(NUM_BEATS - 1)) state_d = ST_DRAIN;
                else if (32'(idle_d) == TIMEOUT)                 state_d = ST_TIMEOUT;
            end
            ST_DRAIN: state_d = (cnt_d == '0) ? ST_PASS : ST_FAIL;
            default: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    beat_d  = '0;
                    idle_d  = '0;
                    cnt_d   = '0;
                    ferr_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            idx_q    <= '0;
            idle_q   <= '0;
            cnt_q    <= '0;
            ferr_q   <= '0;
            vld_q    <= 1'b0;
            epulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            idx_q    <= idx_d;
            idle_q   <= idle_d;
            cnt_q    <= cnt_d;
            ferr_q   <= ferr_d;
            vld_q    <= vld_d;
            epulse_q <= epulse_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.pass      = (state_q == ST_PASS);
    assign bus.fail      = (state_q == ST_FAIL);
    assign bus.timeout   = (state_q == ST_TIMEOUT);
    assign bus.err_pulse = epulse_q;
    assign bus.err_count = cnt_q;
    assign bus.first_err = ferr_q;

endmodule
